rs_cdb_listener: RTL and testbench

//  Reservation station at the receiving end of the common data bus (CDB). Holds dispatched

---
 rtl/rs_cdb_listener_if.sv | 61 ++++++
 rtl/rs_cdb_listener.sv | 157 +++++++++++++++
 tb/tb_rs_cdb_listener.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rs_cdb_listener_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_cdb_listener_if
//  Description : Dispatch, CDB snoop and FU issue signals of the reservation
//                station, with master (pipeline side) and slave (RS) modports.
//  Revision    : 1.0  initial release
// ============================================================================
interface rs_cdb_listener_if #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_rob_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [DATA_W-1:0] cdb_store_data;
  } cdb_packed_s;

  logic               flush_i;
  logic               dispatch_valid_i;
  logic               dispatch_ready_o;
  logic [OP_W-1:0]    dispatch_op_i;
  logic [TAG_W-1:0]   dispatch_rob_tag_i;
  logic               dispatch_src1_rdy_i;
  logic [TAG_W-1:0]   dispatch_src1_tag_i;
  logic [DATA_W-1:0]  dispatch_src1_data_i;
  logic               dispatch_src2_rdy_i;
  logic [TAG_W-1:0]   dispatch_src2_tag_i;
  logic [DATA_W-1:0]  dispatch_src2_data_i;
  cdb_packed_s        cdb_i;
  logic               issue_valid_o;
  logic               issue_yumi_i;
  logic [OP_W-1:0]    issue_op_o;
  logic [TAG_W-1:0]   issue_rob_tag_o;
  logic [DATA_W-1:0]  issue_src1_o;
  logic [DATA_W-1:0]  issue_src2_o;
  logic [c_cnt_w-1:0] count_o;

  modport master (
    output flush_i, dispatch_valid_i, dispatch_op_i, dispatch_rob_tag_i,
           dispatch_src1_rdy_i, dispatch_src1_tag_i, dispatch_src1_data_i,
           dispatch_src2_rdy_i, dispatch_src2_tag_i, dispatch_src2_data_i,
           cdb_i, issue_yumi_i,
    input  dispatch_ready_o, issue_valid_o, issue_op_o, issue_rob_tag_o,
           issue_src1_o, issue_src2_o, count_o
  );

  modport slave (
    input  flush_i, dispatch_valid_i, dispatch_op_i, dispatch_rob_tag_i,
           dispatch_src1_rdy_i, dispatch_src1_tag_i, dispatch_src1_data_i,
           dispatch_src2_rdy_i, dispatch_src2_tag_i, dispatch_src2_data_i,
           cdb_i, issue_yumi_i,
    output dispatch_ready_o, issue_valid_o, issue_op_o, issue_rob_tag_o,
           issue_src1_o, issue_src2_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/rs_cdb_listener.sv
`default_nettype none
// ============================================================================
//  Module      : rs_cdb_listener
//  Description : Reservation station snooping the CDB for operand wakeup and
//                issuing the oldest fully-ready entry with valid/yumi.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_cdb_listener #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  rs_cdb_listener_if.slave  bus
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_idx_w = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_s1_rdy;
  logic [DEPTH-1:0]  r_s2_rdy;
  logic [OP_W-1:0]   r_op      [DEPTH];
  logic [TAG_W-1:0]  r_rob_tag [DEPTH];
  logic [TAG_W-1:0]  r_s1_tag  [DEPTH];
  logic [TAG_W-1:0]  r_s2_tag  [DEPTH];
  logic [DATA_W-1:0] r_s1_data [DEPTH];
  logic [DATA_W-1:0] r_s2_data [DEPTH];
  // r_older[i][j] = 1 when entry i was dispatched before entry j
  logic [DEPTH-1:0]  r_older   [DEPTH];

  logic [DEPTH-1:0]   w_ready_ent;
  logic [DEPTH-1:0]   w_sel;
  logic [DEPTH-1:0]   w_valid_nxt;
  logic [c_cnt_w-1:0] w_count;
  logic [c_idx_w-1:0] w_free_idx;
  logic [OP_W-1:0]    w_issue_op;
  logic [TAG_W-1:0]   w_issue_tag;
  logic [DATA_W-1:0]  w_issue_s1;
  logic [DATA_W-1:0]  w_issue_s2;
  logic               w_disp;
  logic               w_yumi;
  logic               w_issue_valid;
  logic               w_bypass1;
  logic               w_bypass2;
  logic               w_unused_store;

  // Store data travels on the shared CDB but has no consumer here
  assign w_unused_store = ^bus.cdb_i.cdb_store_data;

  // Oldest-ready select, occupancy count, lowest free slot and issue mux
  always_comb begin
    w_ready_ent = r_valid & r_s1_rdy & r_s2_rdy;
    w_sel       = '0;
    w_count     = '0;
    w_free_idx  = '0;
    w_issue_op  = '0;
    w_issue_tag = '0;
    w_issue_s1  = '0;
    w_issue_s2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready_ent[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_ready_ent[j] && r_older[j][i]) w_sel[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + c_cnt_w'(r_valid[i]);
      if (w_sel[i]) begin
        w_issue_op  = w_issue_op  | r_op[i];
        w_issue_tag = w_issue_tag | r_rob_tag[i];
        w_issue_s1  = w_issue_s1  | r_s1_data[i];
        w_issue_s2  = w_issue_s2  | r_s2_data[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = c_idx_w'(i);
    end
  end

  assign w_issue_valid = (|w_ready_ent) & ~bus.flush_i;
  assign w_disp        = bus.dispatch_valid_i & (w_count < c_depth) & ~bus.flush_i;
  assign w_yumi        = bus.issue_yumi_i & w_issue_valid;
  assign w_bypass1     = bus.cdb_i.cdb_valid & (bus.dispatch_src1_tag_i == bus.cdb_i.cdb_rob_tag);
  assign w_bypass2     = bus.cdb_i.cdb_valid & (bus.dispatch_src2_tag_i == bus.cdb_i.cdb_rob_tag);

  // Next valid vector: remove the issued entry, add the dispatched one
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_yumi) w_valid_nxt = w_valid_nxt & ~w_sel;
    if (w_disp) w_valid_nxt[w_free_idx] = 1'b1;
  end

  // Entry storage: flush/issue/dispatch bookkeeping, CDB wakeup, age matrix
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid  <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]      <= '0;
        r_rob_tag[i] <= '0;
        r_s1_tag[i]  <= '0;
        r_s2_tag[i]  <= '0;
        r_s1_data[i] <= '0;
        r_s2_data[i] <= '0;
        r_older[i]   <= '0;
      end
    end else if (bus.flush_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_i.cdb_valid && r_valid[i]) begin
          if (!r_s1_rdy[i] && r_s1_tag[i] == bus.cdb_i.cdb_rob_tag) begin
            r_s1_rdy[i]  <= 1'b1;
            r_s1_data[i] <= bus.cdb_i.cdb_data;
          end
          if (!r_s2_rdy[i] && r_s2_tag[i] == bus.cdb_i.cdb_rob_tag) begin
            r_s2_rdy[i]  <= 1'b1;
            r_s2_data[i] <= bus.cdb_i.cdb_data;
          end
        end
      end
      if (w_disp) begin
        r_op[w_free_idx]      <= bus.dispatch_op_i;
        r_rob_tag[w_free_idx] <= bus.dispatch_rob_tag_i;
        r_s1_tag[w_free_idx]  <= bus.dispatch_src1_tag_i;
        r_s2_tag[w_free_idx]  <= bus.dispatch_src2_tag_i;
        // A waiting source whose producer is on the CDB right now is captured here
        r_s1_rdy[w_free_idx]  <= bus.dispatch_src1_rdy_i | w_bypass1;
        r_s2_rdy[w_free_idx]  <= bus.dispatch_src2_rdy_i | w_bypass2;
        r_s1_data[w_free_idx] <= bus.dispatch_src1_rdy_i ? bus.dispatch_src1_data_i
                               : (w_bypass1 ? bus.cdb_i.cdb_data : '0);
        r_s2_data[w_free_idx] <= bus.dispatch_src2_rdy_i ? bus.dispatch_src2_data_i
                               : (w_bypass2 ? bus.cdb_i.cdb_data : '0);
        // The new entry is younger than every currently valid entry
        r_older[w_free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          r_older[j][w_free_idx] <= r_valid[j];
        end
      end
    end
  end

  assign bus.dispatch_ready_o = (w_count < c_depth);
  assign bus.issue_valid_o    = w_issue_valid;
  assign bus.issue_op_o       = w_issue_op;
  assign bus.issue_rob_tag_o  = w_issue_tag;
  assign bus.issue_src1_o     = w_issue_s1;
  assign bus.issue_src2_o     = w_issue_s2;
  assign bus.count_o          = w_count;

endmodule
`default_nettype wire

// File: tb/tb_rs_cdb_listener.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_cdb_listener
//  Description : Directed self-checking bench for rs_cdb_listener.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_cdb_listener;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rs_cdb_listener_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  rs_cdb_listener #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i              = 1'b0;
    bus.dispatch_valid_i     = 1'b0;
    bus.dispatch_op_i        = '0;
    bus.dispatch_rob_tag_i   = '0;
    bus.dispatch_src1_rdy_i  = 1'b0;
    bus.dispatch_src1_tag_i  = '0;
    bus.dispatch_src1_data_i = '0;
    bus.dispatch_src2_rdy_i  = 1'b0;
    bus.dispatch_src2_tag_i  = '0;
    bus.dispatch_src2_data_i = '0;
    bus.issue_yumi_i         = 1'b0;
    bus.cdb_i.cdb_valid      = 1'b0;
    bus.cdb_i.cdb_rob_tag    = '0;
    bus.cdb_i.cdb_data       = '0;
    bus.cdb_i.cdb_store_data = 32'hDEAD_BEEF;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic r1, input logic [3:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [3:0] t2, input logic [31:0] d2);
    bus.dispatch_valid_i     = 1'b1;
    bus.dispatch_op_i        = op;
    bus.dispatch_rob_tag_i   = rob;
    bus.dispatch_src1_rdy_i  = r1;
    bus.dispatch_src1_tag_i  = t1;
    bus.dispatch_src1_data_i = d1;
    bus.dispatch_src2_rdy_i  = r2;
    bus.dispatch_src2_tag_i  = t2;
    bus.dispatch_src2_data_i = d2;
  endtask

  task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_i.cdb_valid   = v;
    bus.cdb_i.cdb_rob_tag = tag;
    bus.cdb_i.cdb_data    = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #23 rst_n = 1'b1;
    #1;
    check("rst_count",   64'(bus.count_o), 64'd0);
    check("rst_ready",   64'(bus.dispatch_ready_o), 64'd1);
    check("rst_ivalid",  64'(bus.issue_valid_o), 64'd0);
    check("rst_src1",    64'(bus.issue_src1_o), 64'd0);

    // Operand wakeup two cycles after dispatch
    step();
    disp(4'd2, 4'd1, 1'b1, 4'd0, 32'd5, 1'b0, 4'd3, 32'd0);
    step(); idle(); #1;
    check("w_count1",    64'(bus.count_o), 64'd1);
    check("w_wait",      64'(bus.issue_valid_o), 64'd0);
    step();
    cdb(1'b1, 4'd3, 32'h1234); #1;
    check("w_no_comb",   64'(bus.issue_valid_o), 64'd0);
    step(); idle(); #1;
    check("w_valid",     64'(bus.issue_valid_o), 64'd1);
    check("w_src1",      64'(bus.issue_src1_o), 64'd5);
    check("w_src2",      64'(bus.issue_src2_o), 64'h1234);
    check("w_rob",       64'(bus.issue_rob_tag_o), 64'd1);
    check("w_op",        64'(bus.issue_op_o), 64'd2);
    bus.issue_yumi_i = 1'b1;
    step(); idle(); #1;
    check("w_drained",   64'(bus.count_o), 64'd0);

    // Dispatch bypass from a same-cycle CDB broadcast
    disp(4'd3, 4'd4, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'h11);
    cdb(1'b1, 4'd7, 32'hAA); #1;
    check("b_no_comb",   64'(bus.issue_valid_o), 64'd0);
    step(); idle(); #1;
    check("b_valid",     64'(bus.issue_valid_o), 64'd1);
    check("b_src1",      64'(bus.issue_src1_o), 64'hAA);
    check("b_src2",      64'(bus.issue_src2_o), 64'h11);
    bus.issue_yumi_i = 1'b1;
    step(); idle();

    // Tag 0 is an ordinary tag; an invalid CDB wakes nothing
    disp(4'd1, 4'd6, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h22);
    step(); idle();
    cdb(1'b0, 4'd0, 32'h77);
    step(); idle(); #1;
    check("t0_gated",    64'(bus.issue_valid_o), 64'd0);
    cdb(1'b1, 4'd0, 32'h55);
    step(); idle(); #1;
    check("t0_valid",    64'(bus.issue_valid_o), 64'd1);
    check("t0_src1",     64'(bus.issue_src1_o), 64'h55);
    bus.issue_yumi_i = 1'b1;
    step(); idle();

    // Age order: A then B wake together, A issues first
    disp(4'd5, 4'd1, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'h1);
    step();
    disp(4'd6, 4'd2, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'h2);
    step(); idle();
    cdb(1'b1, 4'd9, 32'h99); #1;
    check("a_wait",      64'(bus.issue_valid_o), 64'd0);
    step(); idle(); #1;
    check("a_first",     64'(bus.issue_rob_tag_o), 64'd1);
    check("a_src1",      64'(bus.issue_src1_o), 64'h99);
    bus.issue_yumi_i = 1'b1;
    step(); idle(); #1;
    check("a_second",    64'(bus.issue_rob_tag_o), 64'd2);
    check("a_src2",      64'(bus.issue_src2_o), 64'h2);
    check("a_count",     64'(bus.count_o), 64'd1);
    bus.issue_yumi_i = 1'b1;
    step(); idle(); #1;
    check("a_empty",     64'(bus.count_o), 64'd0);

    // Fill all entries; yumi does not free a slot for same-cycle dispatch
    for (int k = 1; k <= DEPTH; k++) begin
      disp(4'd7, 4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k));
      step();
    end
    idle(); #1;
    check("f_count",     64'(bus.count_o), 64'd4);
    check("f_ready",     64'(bus.dispatch_ready_o), 64'd0);
    check("f_oldest",    64'(bus.issue_rob_tag_o), 64'd1);
    disp(4'd7, 4'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
    bus.issue_yumi_i = 1'b1;
    step(); idle(); #1;
    check("f_count3",    64'(bus.count_o), 64'd3);
    check("f_ready3",    64'(bus.dispatch_ready_o), 64'd1);
    check("f_next",      64'(bus.issue_rob_tag_o), 64'd2);
    disp(4'd7, 4'd6, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'd6);
    bus.issue_yumi_i = 1'b1;
    step(); idle(); #1;
    check("s_count",     64'(bus.count_o), 64'd3);
    check("s_next",      64'(bus.issue_rob_tag_o), 64'd3);

    // Flush with a matching CDB broadcast
    bus.flush_i = 1'b1;
    cdb(1'b1, 4'd3, 32'h5A5A); #1;
    check("fl_ivalid",   64'(bus.issue_valid_o), 64'd0);
    step(); idle(); #1;
    check("fl_count",    64'(bus.count_o), 64'd0);
    check("fl_ivalid2",  64'(bus.issue_valid_o), 64'd0);
    check("fl_ready",    64'(bus.dispatch_ready_o), 64'd1);

    // Asynchronous reset mid-run with three entries
    for (int k = 1; k <= 3; k++) begin
      disp(4'd8, 4'(k), 1'b1, 4'd0, 32'(k), 1'b0, 4'd12, 32'd0);
      step();
    end
    idle(); #1;
    check("r_count3",    64'(bus.count_o), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("r_count0",    64'(bus.count_o), 64'd0);
    check("r_ivalid",    64'(bus.issue_valid_o), 64'd0);
    check("r_ready",     64'(bus.dispatch_ready_o), 64'd1);
    #2 rst_n = 1'b1;
    step(); #1;
    check("r_stays0",    64'(bus.count_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
